// File: rtl/ooo_wb_arbiter.sv
// Write-back arbiter: four 2-deep per-unit result FIFOs share one completion-buffer write port.
// Define OOO_WB_ARITH_PRIO_EN to give unit 0 (arith) strict priority; default is 4-way round-robin.
module ooo_wb_arbiter #(
  parameter int unsigned CB_IDX_W = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic [3:0]            req_valid,
  output logic [3:0]            req_ready,
  input  logic [4*CB_IDX_W-1:0] req_index,
  input  logic [4*DATA_W-1:0]   req_wdata,
  input  logic [19:0]           req_vd,
  input  logic [3:0]            req_exception,
  output logic                  cb_wen,
  output logic [CB_IDX_W-1:0]   cb_index,
  output logic [DATA_W-1:0]     cb_wdata,
  output logic [4:0]            cb_vd,
  output logic                  cb_exception,
  output logic [1:0]            cb_unit,
  input  logic                  cb_ready
);

  localparam int unsigned NUM_UNITS = 4;
  localparam int unsigned DEPTH     = 2;
  localparam int unsigned VD_W      = 5;

  typedef struct packed {
    logic [CB_IDX_W-1:0] index;
    logic [DATA_W-1:0]   wdata;
    logic [VD_W-1:0]     vd;
    logic                exception;
  } entry_t;

  entry_t     mem_q     [NUM_UNITS][DEPTH];
  entry_t     req_entry [NUM_UNITS];
  entry_t     head;

  logic [1:0] count_q   [NUM_UNITS];
  logic [1:0] count_d   [NUM_UNITS];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       lock_q, lock_d;
  logic [1:0] locked_unit_q, locked_unit_d;

  logic [3:0] nonempty;
  logic [3:0] enq;
  logic [3:0] pop;
  logic [1:0] grant;
  logic [1:0] grant_rr;
  logic [1:0] cand;
  logic       found;
  logic       arith_win;
  logic       transfer;

  // Per-unit occupancy, acceptance and incoming entry unpacking
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      nonempty[u]            = (count_q[u] != 2'd0);
      req_ready[u]           = (count_q[u] < 2'd2) & ~RST;
      enq[u]                 = req_valid[u] & req_ready[u] & ~flush;
      req_entry[u].index     = req_index[u*CB_IDX_W +: CB_IDX_W];
      req_entry[u].wdata     = req_wdata[u*DATA_W +: DATA_W];
      req_entry[u].vd        = req_vd[u*VD_W +: VD_W];
      req_entry[u].exception = req_exception[u];
    end
  end

  // Grant selection: held while locked, otherwise priority/round-robin search from rr_ptr
  always_comb begin
    grant_rr  = 2'd0;
    cand      = 2'd0;
    found     = 1'b0;
    arith_win = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = rr_ptr_q + 2'(i);
`ifdef OOO_WB_ARITH_PRIO_EN
      if (!found && nonempty[cand] && (cand != 2'd0)) begin
`else
      if (!found && nonempty[cand]) begin
`endif
        grant_rr = cand;
        found    = 1'b1;
      end
    end
`ifdef OOO_WB_ARITH_PRIO_EN
    arith_win = nonempty[0];
`endif
    if (lock_q) begin
      grant = locked_unit_q;
    end else if (arith_win) begin
      grant = 2'd0;
    end else begin
      grant = grant_rr;
    end
  end

  assign cb_wen   = (|nonempty) & ~flush & ~RST;
  assign transfer = cb_wen & cb_ready;
  assign head     = mem_q[grant][rd_ptr_q[grant]];

  // Fields are forced to zero when no write is offered so reset/idle never exposes stale storage
  always_comb begin
    cb_index     = '0;
    cb_wdata     = '0;
    cb_vd        = '0;
    cb_exception = 1'b0;
    cb_unit      = 2'd0;
    if (cb_wen) begin
      cb_index     = head.index;
      cb_wdata     = head.wdata;
      cb_vd        = head.vd;
      cb_exception = head.exception;
      cb_unit      = grant;
    end
  end

  // Next-state: FIFO bookkeeping, round-robin pointer and lock
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    locked_unit_d = locked_unit_q;
    pop           = 4'b0000;
    for (int u = 0; u < NUM_UNITS; u++) begin
      count_d[u] = count_q[u];
      pop[u]     = transfer & (grant == 2'(u));
      if (enq[u]) begin
        wr_ptr_d[u] = ~wr_ptr_q[u];
      end
      if (pop[u]) begin
        rd_ptr_d[u] = ~rd_ptr_q[u];
      end
      case ({enq[u], pop[u]})
        2'b10:   count_d[u] = count_q[u] + 2'd1;
        2'b01:   count_d[u] = count_q[u] - 2'd1;
        default: count_d[u] = count_q[u];
      endcase
    end

    if (transfer) begin
`ifdef OOO_WB_ARITH_PRIO_EN
      if (grant != 2'd0) begin
        rr_ptr_d = grant + 2'd1;
      end
`else
      rr_ptr_d = grant + 2'd1;
`endif
    end

    if (flush) begin
      lock_d = 1'b0;
    end else if (transfer) begin
      lock_d = 1'b0;
    end else if (cb_wen) begin
      lock_d        = 1'b1;
      locked_unit_d = grant;
    end

    // Flush wipes every FIFO but keeps the fairness pointer
    if (flush) begin
      wr_ptr_d = 4'b0000;
      rd_ptr_d = 4'b0000;
      for (int u = 0; u < NUM_UNITS; u++) begin
        count_d[u] = 2'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        count_q[u] <= 2'd0;
      end
      wr_ptr_q      <= 4'b0000;
      rd_ptr_q      <= 4'b0000;
      rr_ptr_q      <= 2'd0;
      lock_q        <= 1'b0;
      locked_unit_q <= 2'd0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        count_q[u] <= count_d[u];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      locked_unit_q <= locked_unit_d;
    end
  end

  // Entry storage is data-only; validity lives in the counts
  always_ff @(posedge CLK) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (enq[u]) begin
        mem_q[u][wr_ptr_q[u]] <= req_entry[u];
      end
    end
  end

endmodule

// File: tb/tb_ooo_wb_arbiter.sv
// Directed bench for ooo_wb_arbiter; expectations follow OOO_WB_ARITH_PRIO_EN when defined.
module tb_ooo_wb_arbiter;

  localparam int unsigned CB = 4;
  localparam int unsigned DW = 32;

  logic            CLK;
  logic            RST;
  logic            flush;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [4*CB-1:0] req_index;
  logic [4*DW-1:0] req_wdata;
  logic [19:0]     req_vd;
  logic [3:0]      req_exception;
  logic            cb_wen;
  logic [CB-1:0]   cb_index;
  logic [DW-1:0]   cb_wdata;
  logic [4:0]      cb_vd;
  logic            cb_exception;
  logic [1:0]      cb_unit;
  logic            cb_ready;

  int n_cmp = 0;
  int n_err = 0;
  int exp_order [4];

  ooo_wb_arbiter #(.CB_IDX_W(CB), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_wdata(req_wdata), .req_vd(req_vd), .req_exception(req_exception),
    .cb_wen(cb_wen), .cb_index(cb_index), .cb_wdata(cb_wdata), .cb_vd(cb_vd),
    .cb_exception(cb_exception), .cb_unit(cb_unit), .cb_ready(cb_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int u, input logic [3:0] idx, input logic [31:0] wd);
    req_valid[u]         = 1'b1;
    req_index[u*4 +: 4]  = idx;
    req_wdata[u*32 +: 32] = wd;
    req_vd[u*5 +: 5]     = 5'(u + 1);
    req_exception[u]     = 1'b0;
  endtask

  task automatic grant_is(input string tag, input int u, input logic [3:0] idx);
    chk({tag, "_wen"}, 64'(cb_wen), 64'd1);
    chk({tag, "_unit"}, 64'(cb_unit), 64'(u));
    chk({tag, "_idx"}, 64'(cb_index), 64'(idx));
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; cb_ready = 1'b0;
    req_valid = '0; req_index = '0; req_wdata = '0; req_vd = '0; req_exception = '0;

    // Reset state
    #3;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wen", 64'(cb_wen), 64'h0);
    chk("rst_index", 64'(cb_index), 64'h0);
    chk("rst_unit", 64'(cb_unit), 64'h0);
    step(); step();
    RST = 1'b0; #2;
    chk("post_rst_ready", 64'(req_ready), 64'hf);
    chk("post_rst_wen", 64'(cb_wen), 64'h0);
    chk("post_rst_wdata", 64'(cb_wdata), 64'h0);
    chk("post_rst_vd", 64'(cb_vd), 64'h0);
    chk("post_rst_exc", 64'(cb_exception), 64'h0);

    // Single push on unit 2, one-cycle latency
    cb_ready = 1'b1;
    push(2, 4'd5, 32'hDEAD);
    req_vd[14:10] = 5'd7; req_exception[2] = 1'b1;
    #2;
    chk("u2_same_cycle_wen", 64'(cb_wen), 64'h0);
    step(); req_valid = '0; #2;
    grant_is("u2", 2, 4'd5);
    chk("u2_wdata", 64'(cb_wdata), 64'hDEAD);
    chk("u2_vd", 64'(cb_vd), 64'd7);
    chk("u2_exc", 64'(cb_exception), 64'd1);
    step(); #2;
    chk("u2_after_wen", 64'(cb_wen), 64'h0);

    // All four push together after a fresh reset
    RST = 1'b1; step(); RST = 1'b0;
    for (int u = 0; u < 4; u++) push(u, 4'(u + 1), 32'h100 + 32'(u));
    step(); req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #2;
      grant_is($sformatf("all4_g%0d", k), k, 4'(k + 1));
      chk($sformatf("all4_wd%0d", k), 64'(cb_wdata), 64'h100 + 64'(k));
      step();
    end
    #2;
    chk("all4_done_wen", 64'(cb_wen), 64'h0);

`ifdef OOO_WB_ARITH_PRIO_EN
    // Arith pushing every cycle starves the others
    for (int u = 0; u < 4; u++) push(u, 4'(u + 1), 32'h200 + 32'(u));
    step(); req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      push(0, 4'(8 + k), 32'h300 + 32'(k));
      #2;
      grant_is($sformatf("prio_g%0d", k), 0, (k == 0) ? 4'd1 : 4'(7 + k));
      step();
    end
    req_valid = '0; #2;
    grant_is("prio_tail0", 0, 4'd11); step(); #2;
    grant_is("prio_tail1", 1, 4'd2); step(); #2;
    grant_is("prio_tail2", 2, 4'd3); step(); #2;
    grant_is("prio_tail3", 3, 4'd4); step(); #2;
    chk("prio_done_wen", 64'(cb_wen), 64'h0);
`endif

    // Lock: unit 1 held while cb_ready low and unit 0 arrives
    cb_ready = 1'b0;
    push(1, 4'd9, 32'h111);
    step(); req_valid = '0;
    push(0, 4'd7, 32'h777); #2;
    grant_is("lock_a", 1, 4'd9);
    step(); req_valid = '0; #2;
    grant_is("lock_b", 1, 4'd9);
    chk("lock_b_wd", 64'(cb_wdata), 64'h111);
    step(); #2;
    grant_is("lock_c", 1, 4'd9);
    chk("lock_c_wd", 64'(cb_wdata), 64'h111);
    step(); cb_ready = 1'b1; #2;
    grant_is("lock_d", 1, 4'd9);
    step(); #2;
    grant_is("lock_e", 0, 4'd7);
    step(); #2;
    chk("lock_done_wen", 64'(cb_wen), 64'h0);

    // Unit 3 back-to-back with stalled buffer: third push refused
    cb_ready = 1'b0;
    push(3, 4'd1, 32'hA1); #2;
    chk("fill1_ready", 64'(req_ready[3]), 64'd1);
    step(); push(3, 4'd2, 32'hA2); #2;
    chk("fill2_ready", 64'(req_ready[3]), 64'd1);
    grant_is("fill2", 3, 4'd1);
    step(); push(3, 4'd3, 32'hA3); #2;
    chk("fill3_ready", 64'(req_ready[3]), 64'd0);
    step(); req_valid = '0; cb_ready = 1'b1; #2;
    grant_is("drain1", 3, 4'd1);
    chk("drain1_wd", 64'(cb_wdata), 64'hA1);
    step(); #2;
    grant_is("drain2", 3, 4'd2);
    chk("drain2_wd", 64'(cb_wdata), 64'hA2);
    step(); #2;
    chk("drain_done_wen", 64'(cb_wen), 64'h0);

    // Move rr_ptr to 2 before flushing
    push(1, 4'hC, 32'hCC);
    step(); req_valid = '0; #2;
    grant_is("rr_set", 1, 4'hC);
    step();

    // Flush with both slots of every FIFO full and all valids high
    cb_ready = 1'b0;
    for (int u = 0; u < 4; u++) push(u, 4'(u + 1), 32'h400 + 32'(u));
    step();
    for (int u = 0; u < 4; u++) push(u, 4'(u + 5), 32'h500 + 32'(u));
    #2;
`ifdef OOO_WB_ARITH_PRIO_EN
    chk("pre_flush_unit", 64'(cb_unit), 64'd0);
`else
    chk("pre_flush_unit", 64'(cb_unit), 64'd2);
`endif
    step();
    flush = 1'b1; cb_ready = 1'b1; req_valid = 4'hf; #2;
    chk("flush_wen", 64'(cb_wen), 64'h0);
    chk("flush_ready_full", 64'(req_ready), 64'h0);
    step(); flush = 1'b0; req_valid = '0; #2;
    chk("post_flush_wen", 64'(cb_wen), 64'h0);
    chk("post_flush_ready", 64'(req_ready), 64'hf);
    for (int u = 0; u < 4; u++) push(u, 4'(u + 10), 32'h600 + 32'(u));
    step(); req_valid = '0;
`ifdef OOO_WB_ARITH_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = 1;
`else
    exp_order[0] = 2; exp_order[1] = 3; exp_order[2] = 0; exp_order[3] = 1;
`endif
    for (int k = 0; k < 4; k++) begin
      #2;
      grant_is($sformatf("rr_kept_g%0d", k), exp_order[k], 4'(exp_order[k] + 10));
      step();
    end
    #2;
    chk("rr_kept_done_wen", 64'(cb_wen), 64'h0);

    // Reset while a write is pending drops it
    cb_ready = 1'b0;
    push(0, 4'd3, 32'h33);
    step(); req_valid = '0; #2;
    chk("mid_pending_wen", 64'(cb_wen), 64'd1);
    RST = 1'b1; cb_ready = 1'b1; #2;
    chk("mid_rst_wen", 64'(cb_wen), 64'h0);
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    step(); RST = 1'b0; #2;
    chk("mid_after_wen", 64'(cb_wen), 64'h0);
    chk("mid_after_ready", 64'(req_ready), 64'hf);
    chk("mid_after_index", 64'(cb_index), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ooo_wb_arbiter.md
OOO_WB_ARBITER -- requirements
Module: ooo_wb_arbiter

Interface
REQ-001 SHALL have parameter CB_IDX_W, default 4: completion-buffer index width.
REQ-002 SHALL have parameter DATA_W, default 32: result data width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1: discard all pending results.
REQ-006 SHALL have port req_valid, input, 4: per-unit result valid (0 = arith, 1 = mult, 2 = div, 3 = lsu).
REQ-007 SHALL have port req_ready, output, 4: per-unit accept.
REQ-008 SHALL have port req_index, input, 4xCB_IDX_W: completion-buffer slot per unit.
REQ-009 SHALL have port req_wdata, input, 4xDATA_W: result value or faulting PC.
REQ-010 SHALL have port req_vd, input, 4x5: destination register.
REQ-011 SHALL have port req_exception, input, 4: result carries an exception.
REQ-012 SHALL have port cb_wen, output, 1: write request to the single completion-buffer write port.
REQ-013 SHALL have ports cb_index, cb_wdata, cb_vd and cb_exception, outputs, with widths CB_IDX_W, DATA_W, 5 and 1: the granted entry's fields.
REQ-014 SHALL have port cb_unit, output, 2: the granted unit number.
REQ-015 SHALL have port cb_ready, input, 1: the completion buffer accepts the write this cycle.

Function
REQ-016 SHALL hold a 2-entry FIFO per unit (entry: index, wdata, vd, exception) with a 2-bit count 0..2.
REQ-017 req_ready[u] SHALL equal (count[u] < 2) & ~RST and SHALL have no combinational dependence on cb_ready or req_valid.
REQ-018 An entry SHALL be enqueued on req_valid[u] & req_ready[u] & ~flush.
- It becomes eligible for grant in the next cycle; minimum latency is 1 cycle.
REQ-019 cb_wen SHALL be 1 whenever any FIFO is non-empty and flush = 0.
- cb_* fields are driven combinationally from the head of the granted FIFO.
REQ-020 Unlocked grant SHALL be the first non-empty unit found searching upward from rr_ptr, modulo 4.
REQ-021 A transfer SHALL occur on cb_wen & cb_ready.
- It pops the granted head.
- rr_ptr <= granted unit + 1, mod 4.
REQ-022 If cb_wen = 1 and cb_ready = 0, lock <= 1 and locked_unit <= the granted unit.
- While locked, the grant and all cb_* outputs SHALL stay stable until a transfer or a flush, regardless of new arrivals.
REQ-023 lock SHALL clear on a transfer.
REQ-024 Simultaneous enqueue and pop on one unit SHALL leave the count unchanged and preserve FIFO order.
REQ-025 flush SHALL take priority over enqueue and transfer:
- cb_wen = 0 that cycle.
- Next cycle: all counts 0 and lock 0.
- rr_ptr is unchanged.
REQ-026 FIFO read and write pointers SHALL wrap modulo 2.
- Per-unit order is preserved; no ordering across units.

Reset
REQ-027 While RST = 1 at a clock edge, the next state SHALL be: all counts 0, FIFO pointers 0, rr_ptr 0, lock 0.
REQ-028 During and right after reset: cb_wen = 0, cb_index = 0, cb_wdata = 0, cb_vd = 0, cb_exception = 0, cb_unit = 0.
- req_ready = 4'b0000 while RST = 1 and 4'b1111 in the first cycle after RST falls.
REQ-029 Reset asserted mid-transfer SHALL drop all pending entries without producing a write.

Configuration
REQ-030 Macro OOO_WB_ARITH_PRIO_EN SHALL select the grant policy.
- Defined: when unlocked and FIFO 0 is non-empty, unit 0 (arith) SHALL always win. Otherwise round-robin over units 1..3 per REQ-020, with unit 0 skipped. rr_ptr updates only on non-arith transfers.
- Undefined: pure 4-way round-robin per REQ-020.

Verification
REQ-031 Reset, then unit 2 pushes index 5, wdata 0xDEAD, with cb_ready = 1 -> next cycle cb_wen = 1, cb_unit = 2, cb_index = 5, cb_wdata = 0xDEAD; one cycle later cb_wen = 0.
REQ-032 All four units push one entry together, cb_ready = 1, macro undefined -> grants 0, 1, 2, 3 on consecutive cycles.
- With the macro defined and arith pushing every cycle -> only unit 0 is granted.
REQ-033 cb_ready = 0 for 3 cycles while unit 1 is granted and unit 0 pushes -> cb_unit stays 1 with fields stable.
- Unit 1 transfers on the first cycle with cb_ready = 1.
REQ-034 Unit 3 pushes 3 times back-to-back with cb_ready = 0 -> req_ready[3] = 0 after the 2nd accept and the 3rd is not accepted.
- Once cb_ready = 1, the entries drain in push order.
REQ-035 flush with 2 entries queued in each FIFO and req_valid = 4'b1111 -> cb_wen = 0 that cycle and the next; nothing is enqueued; rr_ptr is retained.
